// File: rtl/sram_ctrl_pkg.sv
// Shared definitions for the external 16-bit SRAM sequencer.
package sram_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    STROBE = 3'd2,
    HOLD   = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam logic HALF_LO = 1'b0;
  localparam logic HALF_HI = 1'b1;

  // Strobe-phase down-counter width; covers WAIT_STATES up to 15.
  localparam int WAIT_CNT_W = 4;

endpackage

// File: rtl/sram_ctrl32.sv
// sram_ctrl32: turns one 32-bit CPU word request into two 16-bit
// asynchronous SRAM accesses (low half, then high half), each with
// setup / strobe / hold phases so the pad drivers and the SRAM never fight.
// All outputs are registered: next-cycle values are derived from the next
// state and loaded together with it.
// Build option: define SRAM_WRITE_POST_EN for posted writes (ready one
// cycle after a write is accepted, transfer finishes in the background).
module sram_ctrl32
  import sram_ctrl_pkg::*;
#(
  parameter int WAIT_STATES = 1,
  parameter int ADDR_W      = 17
) (
  input  logic              clk,
  input  logic              reset_b,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              ready,
  output logic [31:0]       rdata,
  output logic              busy,
  output logic [ADDR_W:0]   sram_adr,
  output logic              sram_cs_b,
  output logic              sram_oe_b,
  output logic              sram_we_b,
  output logic [15:0]       sram_dout,
  output logic              sram_dout_en,
  input  logic [15:0]       sram_din
);

`ifdef SRAM_WRITE_POST_EN
  localparam logic POST_WR = 1'b1;
`else
  localparam logic POST_WR = 1'b0;
`endif

  localparam logic [WAIT_CNT_W-1:0] CNT_LOAD = WAIT_CNT_W'(WAIT_STATES - 1);

  state_t                  state_q, state_d;
  logic                    half_q, half_d;
  logic [WAIT_CNT_W-1:0]   cnt_q, cnt_d;
  logic                    we_q, we_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic [31:0]             wdata_q, wdata_d;

  logic                    accept;
  logic                    capture;
  logic                    ready_d;
  logic                    busy_d;
  logic [ADDR_W:0]         adr_d;
  logic                    cs_b_d;
  logic                    oe_b_d;
  logic                    we_b_d;
  logic [15:0]             dout_d;
  logic                    dout_en_d;
  logic [31:0]             rdata_d;

  assign accept  = (state_q == IDLE) && req;
  // Last strobe cycle of a read half: SRAM data has had the full strobe to settle.
  assign capture = (state_q == STROBE) && (cnt_q == '0) && !we_q;

  // Next-state, half select and wait counter sequencing.
  always_comb begin
    state_d = state_q;
    half_d  = half_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          we_d    = we;
          addr_d  = addr;
          wdata_d = wdata;
          half_d  = HALF_LO;
          state_d = SETUP;
        end
      end
      SETUP: begin
        cnt_d   = CNT_LOAD;
        state_d = STROBE;
      end
      STROBE: begin
        if (cnt_q == '0) state_d = HOLD;
        else             cnt_d   = cnt_q - 1'b1;
      end
      HOLD: begin
        if (half_q == HALF_LO) begin
          half_d  = HALF_HI;
          state_d = SETUP;
        end else begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bus strobes and handshake outputs for the cycle the next state occupies.
  always_comb begin
    busy_d    = (state_d != IDLE);
    cs_b_d    = !(state_d inside {SETUP, STROBE, HOLD});
    oe_b_d    = !(!we_d && (state_d inside {SETUP, STROBE}));
    we_b_d    = !(we_d && (state_d == STROBE));
    // Data stays driven through HOLD so it outlives the WE rising edge.
    dout_en_d = we_d && (state_d inside {STROBE, HOLD});
    adr_d     = sram_adr;
    dout_d    = sram_dout;
    if (state_d == SETUP) begin
      adr_d = {addr_d, half_d};
      if (we_d) dout_d = (half_d == HALF_HI) ? wdata_d[31:16] : wdata_d[15:0];
    end
    if (POST_WR) ready_d = (accept && we) || ((state_d == DONE) && !we_q);
    else         ready_d = (state_d == DONE);
    rdata_d = rdata;
    if (capture) begin
      if (half_q == HALF_HI) rdata_d = {sram_din, rdata[15:0]};
      else                   rdata_d = {rdata[31:16], sram_din};
    end
  end

  // Control state and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset_b) begin
      state_q      <= IDLE;
      half_q       <= HALF_LO;
      cnt_q        <= '0;
      we_q         <= 1'b0;
      ready        <= 1'b0;
      busy         <= 1'b0;
      rdata        <= '0;
      sram_adr     <= '0;
      sram_cs_b    <= 1'b1;
      sram_oe_b    <= 1'b1;
      sram_we_b    <= 1'b1;
      sram_dout    <= '0;
      sram_dout_en <= 1'b0;
    end else begin
      state_q      <= state_d;
      half_q       <= half_d;
      cnt_q        <= cnt_d;
      we_q         <= we_d;
      ready        <= ready_d;
      busy         <= busy_d;
      rdata        <= rdata_d;
      sram_adr     <= adr_d;
      sram_cs_b    <= cs_b_d;
      sram_oe_b    <= oe_b_d;
      sram_we_b    <= we_b_d;
      sram_dout    <= dout_d;
      sram_dout_en <= dout_en_d;
    end
  end

  // Request payload latched at acceptance; only meaningful while busy.
  always_ff @(posedge clk) begin
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
  end

endmodule

// File: doc/sram_ctrl32.md
# sram_ctrl32

Sequencer for the board's external 16-bit asynchronous SRAM on behalf of the 32-bit CPU. Each 32-bit word request becomes two 16-bit half accesses: low half first, then high half. For each half the block drives the address, the chip/output/write strobes and the tristate data enable with explicit setup, strobe and hold phases, so the bus never contends. It sits between the CPU address/data mux and the SB_IO data pads. It replaces the hard-wired `wegate`/`RAMOE_b` gluing with a proper request/ready handshake that the system uses to generate the CPU clock enable.

## Interface
Parameters:
- `WAIT_STATES`, default 1: strobe-phase length in cycles per half access; legal range 1..15.
- `ADDR_W`, default 17: CPU word-address bits used. SRAM address width is `ADDR_W+1`.

Ports:
- `clk` in 1: single system clock. The block has one clock.
- `reset_b` in 1: reset, synchronous and active-low.
- `req` in 1: access request. Must be held with `we`/`addr`/`wdata` stable until `ready`.
- `we` in 1: 1 = write, 0 = read.
- `addr` in `ADDR_W`: 32-bit word address.
- `wdata` in 32: write data.
- `ready` out 1: one-cycle completion pulse.
- `rdata` out 32: read data. Valid from the `ready` cycle and held until the next read completes.
- `busy` out 1: high whenever state ≠ IDLE.
- `sram_adr` out `ADDR_W+1`: halfword address `{addr, half}`.
- `sram_cs_b` out 1: chip select.
- `sram_oe_b` out 1: output enable.
- `sram_we_b` out 1: write enable.
- `sram_dout` out 16: pad output data.
- `sram_dout_en` out 1: pad output enable.
- `sram_din` in 16: pad input data.

## Operation
- All outputs are registered.
- Reset values:
  - `ready`=0, `busy`=0, `rdata`=0.
  - `sram_adr`=0, `sram_cs_b`=1, `sram_oe_b`=1, `sram_we_b`=1.
  - `sram_dout`=0, `sram_dout_en`=0.
- FSM states: IDLE, SETUP, STROBE, HOLD, DONE. A `half` flag (0 = low, 1 = high) records which half is in progress.
- IDLE:
  - With `req`=1: latch `we`/`addr`/`wdata`, set `half`=0, go to SETUP.
  - Otherwise remain in IDLE with all strobes inactive.
- SETUP (1 cycle):
  - `sram_adr`={addr,half}, `sram_cs_b`=0.
  - Read: `sram_oe_b`=0.
  - Write: `sram_we_b`=1, `sram_dout_en`=0, `sram_dout` = selected half of `wdata`.
- STROBE (`WAIT_STATES` cycles, down-counter):
  - Write: `sram_we_b`=0, `sram_dout_en`=1.
  - Read: `sram_oe_b`=0; `sram_din` is captured into `rdata[15:0]` (half 0) or `rdata[31:16]` (half 1) on the last STROBE cycle.
- HOLD (1 cycle):
  - `sram_we_b`=1, `sram_oe_b`=1.
  - Write: `sram_dout_en` remains 1 (data hold after the WE rising edge).
  - Address is unchanged.
  - If `half`=0: set `half`=1 and go to SETUP. Otherwise go to DONE.
- DONE (1 cycle): `ready`=1, `sram_cs_b`=1, `sram_dout_en`=0, then go to IDLE.
- `sram_dout_en` and `sram_oe_b`=0 are never asserted in the same cycle.
- `req` dropping mid-transaction does not abort it; both halves complete and `ready` still pulses.
- `reset_b`=0 in any state: on the next edge all strobes go inactive, `sram_dout_en`=0 and state=IDLE. A partial write to the SRAM is accepted as lost.
- A new `req` is sampled only in IDLE; back-to-back requests therefore have one IDLE cycle between them.

## Timing
- Let edge 0 be the edge that samples `req` in IDLE. `ready` is high in cycle 2·(`WAIT_STATES`+2)+1 after edge 0. With `WAIT_STATES`=1 that is cycle 7.
- Per half: address setup to strobe = 1 cycle; strobe width = `WAIT_STATES` cycles; write data hold = 1 cycle.
- At 25 MHz with `WAIT_STATES`=1, each phase is 40 ns, which is ≥ a 10 ns SRAM tAA/tWP.

## Configuration
- `SRAM_WRITE_POST_EN`:
  - Defined: posted writes. `ready` pulses in the cycle after IDLE accepts a write, and the two-half write then completes in the background with `busy`=1. A request that arrives while `busy`=1 is not accepted until IDLE, and its `ready` follows the normal latency from that acceptance. Reads are unaffected.
  - Undefined: writes report `ready` only in DONE, identical to reads.

## Structure
- Shared package `sram_ctrl_pkg` holds:
  - the state enum (IDLE/SETUP/STROBE/HOLD/DONE);
  - localparams `HALF_LO`=0 and `HALF_HI`=1;
  - the wait-counter width, 4 bits.
- No sub-module: the FSM, wait counter and half-select mux are a single module. The SB_IO pads stay in `system`.

## Test plan
- Write `addr`=0x00010, `wdata`=0xDEADBEEF, then read the same address:
  - SRAM model holds 0xBEEF at halfword 0x00020 and 0xDEAD at 0x00021;
  - `rdata`=0xDEADBEEF;
  - `ready` arrives at cycle 7 for both transfers (`WAIT_STATES`=1).
- `WAIT_STATES`=3, read → `ready` at cycle 11; `sram_oe_b` is low for 4 consecutive cycles per half.
- Bus-contention checker over a random write/read mix → `sram_dout_en` & !`sram_oe_b` never true; `sram_we_b` never falls in the same cycle `sram_adr` changes.
- `req` pulsed for 1 cycle only → full transaction completes and exactly one `ready` pulse occurs.
- `reset_b` asserted in the second STROBE cycle of a write → the next cycle has `sram_we_b`=1, `sram_cs_b`=1, `sram_dout_en`=0, `busy`=0, and `ready` never pulses.
- With `SRAM_WRITE_POST_EN`, a write followed immediately by a read:
  - the write `ready` arrives at cycle 1;
  - the read is accepted only after the write's DONE;
  - `rdata` reflects the posted write data.
